// File: rtl/frame_line_gen_pkg.sv
// rtl/frame_line_gen_pkg.sv - FSM state encoding and default parameters shared by frame_line_gen
package frame_line_gen_pkg;

    localparam int CYC_W_DEF    = 10;
    localparam int ROW_W_DEF    = 12;
    localparam int SKIP_W_DEF   = 4;
    localparam int SYNC_DLY_DEF = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SKIP = 2'd1,
        S_ARM  = 2'd2,
        S_LINE = 2'd3
    } state_t;

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - fixed-latency shift register for the sensor line sync
// Ports:
//   clk_rxg  in   clock
//   rst_rx   in   asynchronous active-high reset, clears every tap
//   sync_x   in   raw line sync
//   sync_d   out  sync_x delayed by exactly SYNC_DLY clocks
module sync_delay_line
    import frame_line_gen_pkg::*;
#(
    parameter int SYNC_DLY = SYNC_DLY_DEF
) (
    input  logic clk_rxg,
    input  logic rst_rx,
    input  logic sync_x,
    output logic sync_d
);

    logic [SYNC_DLY-1:0] taps;

    generate
        if (SYNC_DLY == 1) begin : g_one
            always_ff @(posedge clk_rxg or posedge rst_rx) begin
                if (rst_rx) taps <= '0;
                else        taps <= sync_x;
            end
        end else begin : g_multi
            always_ff @(posedge clk_rxg or posedge rst_rx) begin
                if (rst_rx) taps <= '0;
                else        taps <= {taps[SYNC_DLY-2:0], sync_x};
            end
        end
    endgenerate

    assign sync_d = taps[SYNC_DLY-1];

endmodule

// File: rtl/frame_line_gen.sv
// rtl/frame_line_gen.sv - frame/line/data valid generator driven by a delayed sensor line sync
// Ports:
//   clk_rxg               in   clock, all logic on the rising edge
//   rst_rx                in   asynchronous active-high reset
//   sync_x                in   line sync pulse from sensor timing
//   enable                in   allows a new frame to start
//   reg_cnt_timing_cycle  in   line period T (clamped to >= 2)
//   reg_lval_len          in   lval length L (clamped to 1..T)
//   window_row_length     in   rows per frame N (clamped to >= 1)
//   reg_sync_skip         in   syncs discarded before each frame S
//   fval / lval / dval    out  frame valid, line valid, data valid (dval == lval)
//   frame_done            out  one-clock pulse when the last line's lval falls
//   row_idx               out  current (or last) row index
//   overrun               out  sticky: sync seen mid-line
// Build option: FRAME_LINE_GEN_OVERRUN_DET_EN builds the overrun detector;
// without it overrun is constant 0.
module frame_line_gen
    import frame_line_gen_pkg::*;
#(
    parameter int CYC_W    = CYC_W_DEF,
    parameter int ROW_W    = ROW_W_DEF,
    parameter int SKIP_W   = SKIP_W_DEF,
    parameter int SYNC_DLY = SYNC_DLY_DEF
) (
    input  logic              clk_rxg,
    input  logic              rst_rx,
    input  logic              sync_x,
    input  logic              enable,
    input  logic [CYC_W-1:0]  reg_cnt_timing_cycle,
    input  logic [CYC_W-1:0]  reg_lval_len,
    input  logic [ROW_W-1:0]  window_row_length,
    input  logic [SKIP_W-1:0] reg_sync_skip,
    output logic              fval,
    output logic              lval,
    output logic              dval,
    output logic              frame_done,
    output logic [ROW_W-1:0]  row_idx,
    output logic              overrun
);

    logic sync_d;

    sync_delay_line #(
        .SYNC_DLY (SYNC_DLY)
    ) u_sync_dly (
        .clk_rxg (clk_rxg),
        .rst_rx  (rst_rx),
        .sync_x  (sync_x),
        .sync_d  (sync_d)
    );

    state_t            state;
    logic [CYC_W-1:0]  sh_period;
    logic [CYC_W-1:0]  sh_lval_len;
    logic [ROW_W-1:0]  sh_rows;
    logic [SKIP_W-1:0] sh_skip;
    logic [CYC_W-1:0]  line_cnt;
    logic [SKIP_W-1:0] skip_cnt;

    // Register values are clamped before being latched, so the frame logic
    // only ever sees legal shadow values.
    logic [CYC_W-1:0] period_c;
    logic [CYC_W-1:0] lval_len_c;
    logic [ROW_W-1:0] rows_c;

    always_comb begin
        period_c   = (reg_cnt_timing_cycle < CYC_W'(2)) ? CYC_W'(2) : reg_cnt_timing_cycle;
        lval_len_c = (reg_lval_len == '0) ? CYC_W'(1) : reg_lval_len;
        if (lval_len_c > period_c) lval_len_c = period_c;
        rows_c     = (window_row_length == '0) ? ROW_W'(1) : window_row_length;
    end

    logic              line_last;
    logic              lval_last;
    logic              row_last;
    logic              frame_over;
    logic [SKIP_W:0]   skip_nxt;

    always_comb begin
        line_last  = (line_cnt == sh_period - CYC_W'(1));
        lval_last  = (line_cnt == sh_lval_len - CYC_W'(1));
        row_last   = (row_idx == sh_rows - ROW_W'(1));
        // fval is only ever dropped by the last row, so !fval in S_LINE means
        // the frame's final line is just running out its period.
        frame_over = (lval_last && row_last) || !fval;
        skip_nxt   = {1'b0, skip_cnt} + (SKIP_W+1)'(1);
    end

    always_ff @(posedge clk_rxg or posedge rst_rx) begin
        if (rst_rx) begin
            state       <= S_IDLE;
            sh_period   <= '0;
            sh_lval_len <= '0;
            sh_rows     <= '0;
            sh_skip     <= '0;
            line_cnt    <= '0;
            skip_cnt    <= '0;
            row_idx     <= '0;
            fval        <= 1'b0;
            lval        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    skip_cnt <= '0;
                    if (enable) begin
                        state       <= S_SKIP;
                        sh_period   <= period_c;
                        sh_lval_len <= lval_len_c;
                        sh_rows     <= rows_c;
                        sh_skip     <= reg_sync_skip;
                        row_idx     <= '0;
                    end
                end
                S_SKIP: begin
                    if (sh_skip == '0) begin
                        state <= S_ARM;
                    end else if (sync_d) begin
                        skip_cnt <= skip_nxt[SKIP_W-1:0];
                        if (skip_nxt == {1'b0, sh_skip}) state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (sync_d) begin
                        state    <= S_LINE;
                        fval     <= 1'b1;
                        lval     <= 1'b1;
                        line_cnt <= '0;
                    end
                end
                S_LINE: begin
                    if (lval_last) begin
                        lval <= 1'b0;
                        if (row_last) begin
                            fval       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            row_idx <= row_idx + ROW_W'(1);
                        end
                    end
                    if (line_last) begin
                        if (frame_over) begin
                            state <= S_IDLE;
                        end else if (sync_d) begin
                            // Sync on the period's last cycle restarts at once;
                            // overrides the lval drop above when L == T.
                            line_cnt <= '0;
                            lval     <= 1'b1;
                        end else begin
                            state <= S_ARM;
                        end
                    end else begin
                        line_cnt <= line_cnt + CYC_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dval = lval;

`ifdef FRAME_LINE_GEN_OVERRUN_DET_EN
    always_ff @(posedge clk_rxg or posedge rst_rx) begin
        if (rst_rx)                                    overrun <= 1'b0;
        else if (state == S_IDLE && enable)            overrun <= 1'b0;
        else if (state == S_LINE && sync_d && !line_last) overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_frame_line_gen.sv
// tb/tb_frame_line_gen.sv - scoreboard bench for frame_line_gen with an event-level reference model
module tb_frame_line_gen;

    localparam int CYC_W  = 10;
    localparam int ROW_W  = 12;
    localparam int SKIP_W = 4;
    localparam int DLY    = 6;
    localparam int NEVER  = 32'h3fff_ffff;

    logic              clk_rxg = 1'b0;
    logic              rst_rx  = 1'b1;
    logic              sync_x  = 1'b0;
    logic              enable  = 1'b0;
    logic [CYC_W-1:0]  reg_cnt_timing_cycle = '0;
    logic [CYC_W-1:0]  reg_lval_len = '0;
    logic [ROW_W-1:0]  window_row_length = '0;
    logic [SKIP_W-1:0] reg_sync_skip = '0;
    logic              fval, lval, dval, frame_done, overrun;
    logic [ROW_W-1:0]  row_idx;

    frame_line_gen #(
        .CYC_W (CYC_W), .ROW_W (ROW_W), .SKIP_W (SKIP_W), .SYNC_DLY (DLY)
    ) dut (
        .clk_rxg              (clk_rxg),
        .rst_rx               (rst_rx),
        .sync_x               (sync_x),
        .enable               (enable),
        .reg_cnt_timing_cycle (reg_cnt_timing_cycle),
        .reg_lval_len         (reg_lval_len),
        .window_row_length    (window_row_length),
        .reg_sync_skip        (reg_sync_skip),
        .fval                 (fval),
        .lval                 (lval),
        .dval                 (dval),
        .frame_done           (frame_done),
        .row_idx              (row_idx),
        .overrun              (overrun)
    );

    always #5 clk_rxg = ~clk_rxg;

    // cyc == number of the most recent rising edge
    int cyc = 0;
    always @(posedge clk_rxg) cyc <= cyc + 1;

    typedef struct {
        int start;
        int len;
        int row;
    } line_t;

    line_t exp_lines[$];
    int    exp_fd[$];
    int    f0_k[$];
    bit    exp_ovr;
    int    sx_q[$];
    bit    sync_at[int];
    int    cfg_t, cfg_l, cfg_s, cfg_n0, cfg_n1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: lines are delimited by lval falling or by row_idx moving while
    // lval stays high (back-to-back lines with L == T).
    bit    seg_on = 0;
    int    seg_start, seg_len, seg_row, seg_fv_bad;
    int    dv_bad = 0;
    line_t mon_e;
    int    mon_fd;

    always @(negedge clk_rxg) begin
        if (seg_on && (!lval || int'(row_idx) != seg_row)) begin
            if (exp_lines.size() == 0) begin
                chk("line_unexpected", seg_start, -1);
            end else begin
                mon_e = exp_lines.pop_front();
                chk("line_start", seg_start, mon_e.start);
                chk("line_len",   seg_len,   mon_e.len);
                chk("line_row",   seg_row,   mon_e.row);
            end
            chk("fval_in_line", seg_fv_bad, 0);
            seg_on = 0;
        end
        if (lval && !seg_on) begin
            seg_on     = 1;
            seg_start  = cyc;
            seg_len    = 0;
            seg_row    = int'(row_idx);
            seg_fv_bad = 0;
        end
        if (seg_on) begin
            seg_len++;
            if (fval !== 1'b1) seg_fv_bad++;
        end
        if (dval !== lval) dv_bad++;
        if (frame_done === 1'b1) begin
            if (exp_fd.size() == 0) begin
                chk("frame_done_unexpected", cyc, -1);
            end else begin
                mon_fd = exp_fd.pop_front();
                chk("frame_done_edge", cyc, mon_fd);
            end
            chk("fval_at_done", fval, 0);
        end
    end

    // Reference model: works on sync arrival edges only. A line starts at the
    // first delayed sync at or after the earliest legal edge; the next line may
    // start T' edges later; a frame needs S counted syncs after it starts, and
    // the next frame starts one edge after the final line's period.
    task automatic model(input int e0, input int ed, input int run_end, input int cut);
        int    sd[$];
        int    fs, f, tp, lp, np, arm_from, nxt, k, cnt;
        bit    stop;
        line_t ln;
        exp_lines.delete();
        exp_fd.delete();
        f0_k.delete();
        exp_ovr = 0;
        foreach (sx_q[i]) sd.push_back(sx_q[i] + DLY);
        tp = (cfg_t < 2) ? 2 : cfg_t;
        lp = (cfg_l < 1) ? 1 : cfg_l;
        if (lp > tp) lp = tp;
        fs   = e0;
        f    = 0;
        stop = 0;
        while (!stop && fs < ed && fs < run_end) begin
            np = (f == 0) ? cfg_n0 : cfg_n1;
            if (np < 1) np = 1;
            exp_ovr  = 0;
            arm_from = -1;
            if (cfg_s == 0) begin
                arm_from = fs + 2;
            end else begin
                cnt = 0;
                foreach (sd[i]) begin
                    if (arm_from < 0 && sd[i] > fs) begin
                        cnt++;
                        if (cnt == cfg_s) arm_from = sd[i] + 1;
                    end
                end
            end
            if (arm_from < 0) break;
            nxt = arm_from;
            for (int r = 0; r < np && !stop; r++) begin
                k = -1;
                foreach (sd[i]) if (k < 0 && sd[i] >= nxt) k = sd[i];
                if (k < 0) begin
                    stop = 1;
                end else begin
                    if (f == 0) f0_k.push_back(k);
                    if (k < cut) begin
                        ln.start = k;
                        ln.row   = r;
                        ln.len   = (k + lp > cut) ? cut - k : lp;
                        exp_lines.push_back(ln);
                    end
                    foreach (sd[i]) if (sd[i] > k && sd[i] < k + tp) exp_ovr = 1;
                    nxt = k + tp;
                    if (r == np - 1) begin
                        if (k + lp < cut) exp_fd.push_back(k + lp);
                        fs = k + tp + 1;
                    end
                end
            end
            f++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_rxg);
        rst_rx  = 1'b1;
        sync_x  = 1'b0;
        enable  = 1'b0;
        @(negedge clk_rxg);
        @(negedge clk_rxg);
        chk("rst_fval", fval, 0);
        chk("rst_lval", lval, 0);
        chk("rst_dval", dval, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_row_idx", row_idx, 0);
        rst_rx = 1'b0;
    endtask

    task automatic drive(input int e0, input int ed, input int chg, input int run_end);
        while (cyc < run_end) begin
            @(negedge clk_rxg);
            sync_x            = sync_at.exists(cyc + 1);
            enable            = (cyc + 1 >= e0) && (cyc + 1 < ed);
            window_row_length = ROW_W'((cyc + 1 >= chg) ? cfg_n1 : cfg_n0);
        end
        sync_x = 1'b0;
    endtask

    // mode 0: syncs every 200 clocks; mode 1: random gaps.
    // extra > 0 adds one sync that many clocks after the second sync.
    // ed_rel >= 0 drops enable ed_rel clocks into row 1 of the first frame.
    // cut_row >= 0 pulses reset at line counter cut_lc of that row.
    task automatic scenario(input int t, input int l, input int s, input int n0, input int n1,
                            input int mode, input int extra, input int ed_rel,
                            input int cut_row, input int cut_lc);
        int e0, ed, chg, run_end, tmax, cut, g;
        do_reset();
        cfg_t = t; cfg_l = l; cfg_s = s; cfg_n0 = n0; cfg_n1 = n1;
        reg_cnt_timing_cycle = CYC_W'(t);
        reg_lval_len         = CYC_W'(l);
        reg_sync_skip        = SKIP_W'(s);
        window_row_length    = ROW_W'(n0);
        tmax = (t < 2) ? 2 : t;
        e0   = cyc + 3;
        chg  = e0 + 10;
        sx_q.delete();
        sync_at.delete();
        if (mode == 0) begin
            for (int i = 0; i < 14; i++) sx_q.push_back(e0 + 5 + 200 * i);
        end else begin
            g = e0 + 2;
            for (int i = 0; i < 50; i++) begin
                g += $urandom_range(1, tmax + tmax / 2 + 3);
                sx_q.push_back(g);
            end
        end
        if (extra > 0) begin
            sx_q.push_back(sx_q[1] + extra);
            sx_q.sort();
        end
        foreach (sx_q[i]) sync_at[sx_q[i]] = 1'b1;
        run_end = sx_q[$] + DLY + tmax + 20;
        ed  = NEVER;
        cut = NEVER;
        model(e0, ed, run_end, cut);
        if (ed_rel >= 0 && f0_k.size() > 1) ed = f0_k[1] + ed_rel;
        if (cut_row >= 0 && f0_k.size() > cut_row) cut = f0_k[cut_row] + cut_lc;
        if (ed != NEVER || cut != NEVER) model(e0, ed, run_end, cut);
        dv_bad = 0;
        if (cut != NEVER) begin
            drive(e0, ed, chg, cut - 1);
            @(posedge clk_rxg);
            #2 rst_rx = 1'b1;
            #1;
            chk("async_lval_drop", lval, 0);
            chk("async_fval_drop", fval, 0);
            chk("async_no_done", frame_done, 0);
            @(negedge clk_rxg);
            @(negedge clk_rxg);
            rst_rx = 1'b0;
            chk("overrun_after_reset", overrun, 0);
        end else begin
            drive(e0, ed, chg, run_end);
            @(negedge clk_rxg);
            @(negedge clk_rxg);
`ifdef FRAME_LINE_GEN_OVERRUN_DET_EN
            chk("overrun", overrun, exp_ovr);
`else
            chk("overrun", overrun, 0);
`endif
        end
        chk("lines_left", exp_lines.size(), 0);
        chk("frame_done_left", exp_fd.size(), 0);
        chk("dval_eq_lval", dv_bad, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        scenario(200, 128, 1, 4, 4, 0, 0,  -1, -1, 0);   // nominal frame
        scenario(200, 300, 1, 4, 4, 0, 0,  -1, -1, 0);   // L clamped to T
        scenario(200, 128, 1, 4, 4, 0, 50, -1, -1, 0);   // extra mid-line sync
        scenario(200, 128, 1, 4, 2, 0, 0,  -1, -1, 0);   // N changed mid-frame
        scenario(200, 128, 1, 4, 4, 0, 0,  -1, 2,  60);  // reset on row 2
        scenario(200, 128, 1, 4, 4, 0, 0,  5,  -1, 0);   // enable dropped on row 1
        for (int i = 0; i < 10; i++) begin
            scenario($urandom_range(0, 40), $urandom_range(0, 50), $urandom_range(0, 3),
                     $urandom_range(0, 4), $urandom_range(0, 4), 1, 0, -1, -1, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
